icache_axi_rd: RTL and testbench



---
 rtl/icache_axi_rd_pkg.sv | 18 +
 rtl/icache_axi_rd.sv | 138 +++++++++++++
 tb/tb_icache_axi_rd.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_rd_pkg.sv
// Shared definitions for the instruction-cache AXI line-fill reader:
// FSM state encodings, AXI field encodings and the cache word width.
package icache_axi_rd_pkg;

   typedef enum logic [1:0] {
      ICACHE_AXI_IDLE = 2'd0,
      ICACHE_AXI_AR   = 2'd1,
      ICACHE_AXI_R    = 2'd2,
      ICACHE_AXI_DONE = 2'd3
   } icacheAxiState_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam int WORD_W = 32;

endpackage

// File: rtl/icache_axi_rd.sv
// Instruction-cache line-fill reader: takes one line-fill request from
// icache stage 2, issues a single AXI4 INCR burst of LINE_BEATS x 32-bit
// beats, assembles them into a cache line and signals completion with a
// one-cycle pulse. Only one transaction is ever outstanding, so RID is
// not used.
module icache_axi_rd
   import icache_axi_rd_pkg::*;
#(
   parameter logic [3:0] AXI_ID     = 4'd0,
   parameter int         LINE_BEATS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_i,
   input  logic [31:0]                    addr_i,
   output logic                           busy_o,
   output logic                           rend_o,
   output logic [WORD_W*LINE_BEATS-1:0]   line_o,
   output logic                           err_o,
   output logic [3:0]                     arid,
   output logic [31:0]                    araddr,
   output logic [7:0]                     arlen,
   output logic [2:0]                     arsize,
   output logic [1:0]                     arburst,
   output logic                           arvalid,
   input  logic                           arready,
   input  logic [3:0]                     rid,
   input  logic [31:0]                    rdata,
   input  logic [1:0]                     rresp,
   input  logic                           rlast,
   input  logic                           rvalid,
   output logic                           rready
);

   localparam int LINE_W = WORD_W * LINE_BEATS;
   localparam int CNT_W  = $clog2(LINE_BEATS);
   localparam int OFS_W  = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

   icacheAxiState_t state;
   logic [CNT_W-1:0] cnt;
   logic errFlag;

   logic beatErr;
   logic lastBeat;
   logic protoErr;
   logic errAcc;
   logic unusedBits;

   // The burst shape never changes, so the constant AR fields are plain
   // wires and do not depend on reset.
   assign arid    = AXI_ID;
   assign arlen   = 8'(LINE_BEATS - 1);
   assign arsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;

   // RID and the byte offset within the line carry no information here.
   assign unusedBits = ^{rid, addr_i[OFS_W-1:0]};

   // Per-beat error evaluation. A beat is a protocol error when RLAST
   // disagrees with the beat counter: either RLAST arrives before the final
   // word, or the final word arrives without RLAST. Both cases are caught by
   // the XOR, and both terminate the burst. errAcc is the error flag value
   // including the current beat.
   always_comb begin
      beatErr  = 1'b0;
      lastBeat = 1'b0;
      protoErr = 1'b0;
      errAcc   = 1'b0;
      beatErr  = (rresp != AXI_RESP_OKAY);
      lastBeat = (cnt == LAST_BEAT);
      protoErr = lastBeat ^ rlast;
      errAcc   = errFlag | beatErr | protoErr;
   end

   // Main FSM. All handshake and status outputs are registered here so that
   // nothing downstream sees a combinational path from ARREADY or RVALID.
   // The asynchronous reset drops ARVALID/RREADY immediately and throws away
   // any partially assembled line. On leaving R the line register keeps any
   // words that were not refilled, which is what an early RLAST leaves behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ICACHE_AXI_IDLE;
         cnt     <= '0;
         errFlag <= 1'b0;
         araddr  <= '0;
         line_o  <= '0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         busy_o  <= 1'b0;
         rend_o  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         case (state)
            ICACHE_AXI_IDLE: begin
               if (req_i) begin
                  araddr  <= {addr_i[31:OFS_W], OFS_W'(0)};
                  cnt     <= '0;
                  errFlag <= 1'b0;
                  arvalid <= 1'b1;
                  busy_o  <= 1'b1;
                  state   <= ICACHE_AXI_AR;
               end
            end
            ICACHE_AXI_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ICACHE_AXI_R;
               end
            end
            ICACHE_AXI_R: begin
               if (rvalid) begin
                  line_o[int'(cnt)*WORD_W +: WORD_W] <= rdata;
                  cnt     <= cnt + CNT_W'(1);
                  errFlag <= errAcc;
                  if (lastBeat || rlast) begin
                     rready <= 1'b0;
                     rend_o <= 1'b1;
                     err_o  <= errAcc;
                     state  <= ICACHE_AXI_DONE;
                  end
               end
            end
            ICACHE_AXI_DONE: begin
               rend_o <= 1'b0;
               err_o  <= 1'b0;
               busy_o <= 1'b0;
               state  <= ICACHE_AXI_IDLE;
            end
            default: begin
               state <= ICACHE_AXI_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_axi_rd.sv
// Testbench for icache_axi_rd: directed line fills driven cycle by cycle,
// with expected completions queued at request time and checked by an
// independent monitor whenever the DUT pulses rend_o.
module tb_icache_axi_rd;

   logic         clk;
   logic         rst;
   logic         req_i;
   logic [31:0]  addr_i;
   logic         busy_o;
   logic         rend_o;
   logic [255:0] line_o;
   logic         err_o;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   typedef struct {
      logic [255:0] line;
      logic         err;
      int           cycle;
   } expFill_t;

   expFill_t expQ[$];
   int vectorsApplied = 0;
   int miscompares    = 0;
   int cycleCount     = 0;

   localparam logic [255:0] LINE_NOM  = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
   localparam logic [255:0] LINE_ERR  = 256'hA5A50007_A5A50006_A5A50005_A5A50004_A5A50003_A5A50002_A5A50001_A5A50000;
   localparam logic [255:0] LINE_EARLY = 256'hA5A50007_A5A50006_A5A50005_50000004_50000003_50000002_50000001_50000000;
   localparam logic [255:0] LINE_NOLAST = 256'h77000007_77000006_77000005_77000004_77000003_77000002_77000001_77000000;

   icache_axi_rd #(
      .AXI_ID     (4'd0),
      .LINE_BEATS (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i),
      .addr_i  (addr_i),
      .busy_o  (busy_o),
      .rend_o  (rend_o),
      .line_o  (line_o),
      .err_o   (err_o),
      .arid    (arid),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .arvalid (arvalid),
      .arready (arready),
      .rid     (rid),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to timestamp requests and completions.
   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   // Single comparison point: every check, from the stimulus thread or the
   // monitor, goes through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Completion monitor: samples on the falling edge, pops the oldest
   // expected fill and compares line, error flag and completion cycle.
   always @(negedge clk) begin
      if (!rst && rend_o) begin
         if (expQ.size() == 0) begin
            checkOutput("rend_unexpected", 256'(rend_o), 256'(0));
         end else begin
            expFill_t e;
            e = expQ.pop_front();
            checkOutput("line", line_o, e.line);
            checkOutput("err", 256'(err_o), 256'(e.err));
            checkOutput("rend_cycle", 256'(cycleCount), 256'(e.cycle));
            checkOutput("busy_at_rend", 256'(busy_o), 256'(1));
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete fill, driven cycle by cycle. arDelay: cycles ARREADY is
   // held low; gaps: insert an idle cycle before every beat; errBeat: index
   // of a beat answered with SLVERR; lastAt: 1-based beat carrying RLAST
   // (0 = never); busyReqAt: beat during which a stray request is pulsed;
   // resetAt: beat at which reset is asserted instead of being sent.
   task automatic applyStimulus(input logic [31:0] addr, input int arDelay, input bit gaps,
                                input int errBeat, input int nBeats, input int lastAt,
                                input logic [31:0] base, input logic [31:0] stepVal,
                                input int busyReqAt, input int resetAt,
                                input logic [255:0] expLine, input logic expErr, input int expLatency);
      expFill_t e;
      logic [31:0] expAddr;
      expAddr = {addr[31:5], 5'b0};
      if (resetAt < 0) begin
         e.line  = expLine;
         e.err   = expErr;
         e.cycle = cycleCount + expLatency;
         expQ.push_back(e);
      end
      req_i  = 1'b1;
      addr_i = addr;
      step();
      req_i  = 1'b0;
      addr_i = 32'hDEAD_BEEF;
      checkOutput("arvalid_issue", 256'(arvalid), 256'(1));
      checkOutput("araddr", 256'(araddr), 256'(expAddr));
      checkOutput("busy_issue", 256'(busy_o), 256'(1));
      for (int i = 0; i < arDelay; i++) begin
         arready = 1'b0;
         step();
         checkOutput("araddr_stable", 256'(araddr), 256'(expAddr));
         checkOutput("arvalid_hold", 256'(arvalid), 256'(1));
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      checkOutput("rready_in_r", 256'(rready), 256'(1));
      checkOutput("arvalid_in_r", 256'(arvalid), 256'(0));
      for (int b = 0; b < nBeats; b++) begin
         if (gaps) begin
            rvalid = 1'b0;
            step();
         end
         if (b == resetAt) begin
            rvalid = 1'b0;
            rst    = 1'b1;
            #1;
            checkOutput("rst_arvalid", 256'(arvalid), 256'(0));
            checkOutput("rst_rready", 256'(rready), 256'(0));
            checkOutput("rst_busy", 256'(busy_o), 256'(0));
            checkOutput("rst_line", line_o, 256'(0));
            step();
            rst = 1'b0;
            step();
            return;
         end
         if (b == busyReqAt) begin
            req_i  = 1'b1;
            addr_i = 32'h0000_1000;
         end
         rvalid = 1'b1;
         rdata  = base + 32'(b) * stepVal;
         rresp  = (b == errBeat) ? 2'b10 : 2'b00;
         rlast  = ((b + 1) == lastAt);
         step();
         req_i = 1'b0;
         if (b == busyReqAt) begin
            checkOutput("no_second_ar", 256'(arvalid), 256'(0));
         end
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      step();
      checkOutput("idle_arvalid", 256'(arvalid), 256'(0));
      checkOutput("idle_busy", 256'(busy_o), 256'(0));
   endtask

   // Directed sequence: reset state, nominal, backpressure, error response
   // with a stray request, back-to-back early RLAST, missing RLAST, reset
   // mid-burst and a fresh fill afterwards.
   initial begin
      rst     = 1'b1;
      req_i   = 1'b0;
      addr_i  = '0;
      arready = 1'b0;
      rid     = 4'h5;
      rdata   = '0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      rvalid  = 1'b0;
      step();
      step();
      checkOutput("reset_arvalid", 256'(arvalid), 256'(0));
      checkOutput("reset_rready", 256'(rready), 256'(0));
      checkOutput("reset_busy", 256'(busy_o), 256'(0));
      checkOutput("reset_rend", 256'(rend_o), 256'(0));
      checkOutput("reset_err", 256'(err_o), 256'(0));
      checkOutput("reset_araddr", 256'(araddr), 256'(0));
      checkOutput("reset_line", line_o, 256'(0));
      checkOutput("arlen", 256'(arlen), 256'(7));
      checkOutput("arsize", 256'(arsize), 256'(2));
      checkOutput("arburst", 256'(arburst), 256'(1));
      checkOutput("arid", 256'(arid), 256'(0));
      rst = 1'b0;
      step();

      applyStimulus(32'h1FC0_0014, 0, 1'b0, -1, 8, 8, 32'h1111_1111, 32'h1111_1111, -1, -1, LINE_NOM, 1'b0, 10);
      step();
      applyStimulus(32'h2000_0044, 5, 1'b1, -1, 8, 8, 32'h1111_1111, 32'h1111_1111, -1, -1, LINE_NOM, 1'b0, 23);
      step();
      applyStimulus(32'h3000_0000, 0, 1'b0, 2, 8, 8, 32'hA5A5_0000, 32'h1, 2, -1, LINE_ERR, 1'b1, 10);
      applyStimulus(32'h4000_0008, 0, 1'b0, -1, 5, 5, 32'h5000_0000, 32'h1, -1, -1, LINE_EARLY, 1'b1, 7);
      step();
      applyStimulus(32'h5000_0100, 0, 1'b0, -1, 8, 0, 32'h7700_0000, 32'h1, -1, -1, LINE_NOLAST, 1'b1, 10);
      step();
      applyStimulus(32'h6000_0000, 0, 1'b0, -1, 8, 8, 32'h3300_0000, 32'h1, -1, 4, '0, 1'b0, 0);
      applyStimulus(32'h0000_1000, 0, 1'b0, -1, 8, 8, 32'h1111_1111, 32'h1111_1111, -1, -1, LINE_NOM, 1'b0, 10);

      for (int i = 0; i < 4; i++) begin
         step();
      end
      checkOutput("pending_rend", 256'(expQ.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
